// File: rtl/spi_pkg.sv
// Shared constants, phase type and counter-select helpers for the SPI config slave.
package spi_pkg;

  // Byte-stream phase: first byte of a frame is the address, the rest are data.
  typedef enum logic {
    ADDRESS = 1'b0,
    DATA    = 1'b1
  } phase_e;

  localparam logic [7:0] ADDR_TCM        = 8'd1;
  localparam logic [7:0] ADDR_INST       = 8'd2;
  localparam logic [7:0] ADDR_MODE       = 8'd3;
  localparam logic [7:0] ADDR_CNT_FIRST  = 8'd4;
  localparam logic [7:0] ADDR_CNT_LAST   = 8'd59;
  localparam logic [7:0] ADDR_PLL_LOCKED = 8'd60;
  localparam logic [7:0] ADDR_DISC_POL   = 8'd61;
  localparam logic [7:0] ADDR_VCO_CTRL   = 8'd62;
  localparam logic [7:0] ADDR_PLL_DIV    = 8'd63;
  localparam logic [7:0] ADDR_SLOW_MODE  = 8'd64;
  localparam logic [7:0] ADDR_TRIG_DELAY = 8'd65;

  localparam logic [7:0] INST_RST     = 8'd1;
  localparam logic [7:0] INST_READOUT = 8'd2;
  localparam logic [7:0] INST_START   = 8'd3;

  localparam logic [2:0] SEL_NONE = 3'b111;

  // True for addresses that map onto the external counter chain.
  function automatic logic is_cnt_addr(input logic [7:0] a);
    return (a >= ADDR_CNT_FIRST) && (a <= ADDR_CNT_LAST);
  endfunction

  // Word index inside a channel: seven words per channel.
  function automatic logic [2:0] cnt_word(input logic [7:0] a);
    logic [7:0] off;
    off = a - ADDR_CNT_FIRST;
    return 3'(off % 8'd7);
  endfunction

  // One-hot channel select: channel = offset / 7.
  function automatic logic [7:0] cnt_chan(input logic [7:0] a);
    logic [7:0] off;
    off = a - ADDR_CNT_FIRST;
    return 8'd1 << 3'(off / 8'd7);
  endfunction

endpackage

// File: rtl/spi_shift_in.sv
// Serial deserializer: shift register, bit counter and idle-timeout counter.
// byte_valid/byte_data are combinational so a byte takes effect on its 8th edge.
module spi_shift_in #(
  parameter int IDLE_RESET_CYCLES = 8
) (
  input  logic       iclk,
  input  logic       rstn,
  input  logic       sclk,
  input  logic       serial_in,
  output logic [2:0] bit_idx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       idle_reset
);

  localparam int IW = $clog2(IDLE_RESET_CYCLES + 1);

  logic [6:0]    shreg;
  logic [IW-1:0] idle_cnt;

  assign byte_data  = {shreg, serial_in};
  assign byte_valid = sclk && (bit_idx == 3'd7);
  // Fires on the edge that completes the idle run, and keeps firing while idle persists.
  assign idle_reset = !sclk && (idle_cnt == IW'(IDLE_RESET_CYCLES - 1));

  // Shift in MSB-first and count bits; a timeout discards any partial byte.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (sclk) begin
      shreg   <= byte_data[6:0];
      bit_idx <= bit_idx + 3'd1;
    end else if (idle_reset) begin
      bit_idx <= '0;
    end
  end

  // Count consecutive idle edges, saturating once the timeout is reached.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (sclk) begin
      idle_cnt <= '0;
    end else if (!idle_reset) begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end

endmodule

// File: rtl/spi_ctrl.sv
// Serial configuration/readout slave: address byte, then auto-incrementing
// read/write data bytes, instruction pulses and counter-chain select.
module spi_ctrl
  import spi_pkg::*;
#(
  parameter int IDLE_RESET_CYCLES = 8
) (
  input  logic       iclk,
  input  logic       rstn,
  input  logic       sclk,
  input  logic       serial_in,
  input  logic [7:0] pll_locked,
  output logic [7:0] load_cnt_ser,
  output logic [2:0] select_reg,
  output logic       clk_enable,
  output logic       inst_rst,
  output logic       inst_readout,
  output logic       inst_start,
  output logic [7:0] trigger_channel_mask,
  output logic [7:0] mode,
  output logic [7:0] disc_polarity,
  output logic [7:0] vco_control,
  output logic [7:0] pll_div_ratio,
  output logic [7:0] slow_mode,
  output logic [7:0] trig_delay,
  output logic       serial_out,
  output phase_e     dbg_phase
);

  // Handshake: a bit is accepted on any iclk rise where sclk=1; there is no
  // back-pressure, so the slave always consumes the bit on that edge.

  logic [2:0] bit_idx;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       idle_reset;

  phase_e     phase, next_phase;
  logic [7:0] addr;
  logic [7:0] inst_reg;
  logic       inst_pend;
  logic       data_wr;
  logic [7:0] rd_data;

  spi_shift_in #(
    .IDLE_RESET_CYCLES(IDLE_RESET_CYCLES)
  ) u_shift_in (
    .iclk       (iclk),
    .rstn       (rstn),
    .sclk       (sclk),
    .serial_in  (serial_in),
    .bit_idx    (bit_idx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .idle_reset (idle_reset)
  );

  assign dbg_phase = phase;
  assign data_wr   = byte_valid && (phase == DATA);

  // Phase register.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) phase <= ADDRESS;
    else       phase <= next_phase;
  end

  // Next phase: timeout returns to ADDRESS, first full byte moves to DATA.
  always_comb begin
    next_phase = phase;
    if (idle_reset) begin
      next_phase = ADDRESS;
    end else if (byte_valid && (phase == ADDRESS)) begin
      next_phase = DATA;
    end
  end

  // Address: loaded by the address byte, incremented (wrapping) after each data byte.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      addr <= '0;
    end else if (byte_valid) begin
      if (phase == ADDRESS) addr <= byte_data;
      else                  addr <= addr + 8'd1;
    end
  end

  // Writable configuration registers; other addresses silently ignore writes.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      trigger_channel_mask <= '0;
      inst_reg             <= '0;
      mode                 <= '0;
      disc_polarity        <= '0;
      vco_control          <= '0;
      pll_div_ratio        <= '0;
      slow_mode            <= '0;
      trig_delay           <= '0;
    end else if (data_wr) begin
      case (addr)
        ADDR_TCM:        trigger_channel_mask <= byte_data;
        ADDR_INST:       inst_reg             <= byte_data;
        ADDR_MODE:       mode                 <= byte_data;
        ADDR_DISC_POL:   disc_polarity        <= byte_data;
        ADDR_VCO_CTRL:   vco_control          <= byte_data;
        ADDR_PLL_DIV:    pll_div_ratio        <= byte_data;
        ADDR_SLOW_MODE:  slow_mode            <= byte_data;
        ADDR_TRIG_DELAY: trig_delay           <= byte_data;
        default: ;
      endcase
    end
  end

  // Readback mux; counter words read 0 here because the external chain drives them.
  always_comb begin
    rd_data = '0;
    case (addr)
      ADDR_TCM:        rd_data = trigger_channel_mask;
      ADDR_INST:       rd_data = inst_reg;
      ADDR_MODE:       rd_data = mode;
      ADDR_PLL_LOCKED: rd_data = pll_locked;
      ADDR_DISC_POL:   rd_data = disc_polarity;
      ADDR_VCO_CTRL:   rd_data = vco_control;
      ADDR_PLL_DIV:    rd_data = pll_div_ratio;
      ADDR_SLOW_MODE:  rd_data = slow_mode;
      ADDR_TRIG_DELAY: rd_data = trig_delay;
      default:         rd_data = '0;
    endcase
  end

  // Readback streams LSB-first from pre-write contents, one bit per sampled edge.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn)     serial_out <= 1'b0;
    else if (sclk) serial_out <= rd_data[bit_idx];
  end

  // Instruction execution: pending on write, one-cycle pulse on the next edge.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      inst_pend    <= 1'b0;
      inst_rst     <= 1'b0;
      inst_readout <= 1'b0;
      inst_start   <= 1'b0;
      clk_enable   <= 1'b0;
    end else begin
      inst_pend    <= data_wr && (addr == ADDR_INST);
      inst_rst     <= inst_pend && (inst_reg == INST_RST);
      inst_readout <= inst_pend && (inst_reg == INST_READOUT);
      inst_start   <= inst_pend && (inst_reg == INST_START);
      if (inst_pend && (inst_reg == INST_RST))        clk_enable <= 1'b0;
      else if (inst_pend && (inst_reg == INST_START)) clk_enable <= 1'b1;
    end
  end

  // Counter-chain select, only meaningful once an address has been received.
  always_comb begin
    select_reg   = SEL_NONE;
    load_cnt_ser = '0;
    if ((phase == DATA) && is_cnt_addr(addr)) begin
      select_reg   = cnt_word(addr);
      load_cnt_ser = cnt_chan(addr);
    end
  end

endmodule

// File: tb/tb_spi_ctrl.sv
// Bench for spi_ctrl: table-driven select vectors, directed sequences and
// randomized byte streams checked against a register-map model.
module tb_spi_ctrl;

  localparam int IDLE = 8;

  logic       iclk = 1'b0;
  logic       rstn;
  logic       sclk;
  logic       serial_in;
  logic [7:0] pll_locked;
  logic [7:0] load_cnt_ser;
  logic [2:0] select_reg;
  logic       clk_enable, inst_rst, inst_readout, inst_start;
  logic [7:0] trigger_channel_mask, mode, disc_polarity, vco_control;
  logic [7:0] pll_div_ratio, slow_mode, trig_delay;
  logic       serial_out;
  spi_pkg::phase_e dbg_phase;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0] mem [256];
  int         m_addr, m_bits, m_idle, m_pend;
  bit         m_in_data, m_clk_en;
  logic [7:0] m_sh;

  typedef struct {
    logic [7:0] addr;
    logic [2:0] sel;
    logic [7:0] load;
  } sel_vec_t;
  sel_vec_t sel_tab [11];

  spi_ctrl #(.IDLE_RESET_CYCLES(IDLE)) dut (
    .iclk                 (iclk),
    .rstn                 (rstn),
    .sclk                 (sclk),
    .serial_in            (serial_in),
    .pll_locked           (pll_locked),
    .load_cnt_ser         (load_cnt_ser),
    .select_reg           (select_reg),
    .clk_enable           (clk_enable),
    .inst_rst             (inst_rst),
    .inst_readout         (inst_readout),
    .inst_start           (inst_start),
    .trigger_channel_mask (trigger_channel_mask),
    .mode                 (mode),
    .disc_polarity        (disc_polarity),
    .vco_control          (vco_control),
    .pll_div_ratio        (pll_div_ratio),
    .slow_mode            (slow_mode),
    .trig_delay           (trig_delay),
    .serial_out           (serial_out),
    .dbg_phase            (dbg_phase)
  );

  // Clock
  always #5 iclk = ~iclk;

  // Watchdog
  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] model_rd(input int a);
    if (a == 1 || a == 2 || a == 3 || (a >= 61 && a <= 65)) return mem[a];
    if (a == 60) return pll_locked;
    return 8'h00;
  endfunction

  function automatic bit model_writable(input int a);
    return (a == 1 || a == 2 || a == 3 || (a >= 61 && a <= 65));
  endfunction

  task automatic model_byte(input logic [7:0] b);
    if (!m_in_data) begin
      m_addr    = int'(b);
      m_in_data = 1'b1;
    end else begin
      if (model_writable(m_addr)) mem[m_addr] = b;
      if (m_addr == 2) m_pend = int'(b);
      m_addr = (m_addr + 1) % 256;
    end
  endtask

  // One iclk cycle of stimulus; checks pulses, enable and readback bit.
  task automatic tick(input logic s, input logic d);
    int         p;
    logic [7:0] rv;
    logic       exp_so;
    @(negedge iclk);
    sclk      = s;
    serial_in = d;
    p      = m_pend;
    m_pend = -1;
    rv     = model_rd(m_addr);
    exp_so = rv[m_bits];
    if (s) begin
      m_idle = 0;
      m_sh   = {m_sh[6:0], d};
      m_bits++;
      if (m_bits == 8) begin
        m_bits = 0;
        model_byte(m_sh);
      end
    end else begin
      if (m_idle < IDLE) m_idle++;
      if (m_idle >= IDLE) begin
        m_in_data = 1'b0;
        m_bits    = 0;
      end
    end
    if (p == 1) m_clk_en = 1'b0;
    else if (p == 3) m_clk_en = 1'b1;
    @(posedge iclk);
    #1;
    check("inst_rst",     32'(inst_rst),     32'(p == 1));
    check("inst_readout", 32'(inst_readout), 32'(p == 2));
    check("inst_start",   32'(inst_start),   32'(p == 3));
    check("clk_enable",   32'(clk_enable),   32'(m_clk_en));
    if (s) check("serial_out", 32'(serial_out), 32'(exp_so));
  endtask

  task automatic check_cfg();
    int a;
    int e_sel, e_load;
    a = m_addr;
    if (m_in_data && a >= 4 && a <= 59) begin
      e_sel  = (a - 4) % 7;
      e_load = 1 << ((a - 4) / 7);
    end else begin
      e_sel  = 7;
      e_load = 0;
    end
    check("select_reg",   32'(select_reg),   32'(e_sel));
    check("load_cnt_ser", 32'(load_cnt_ser), 32'(e_load));
    check("phase",        32'(dbg_phase),    32'(m_in_data));
    check("tcm",          32'(trigger_channel_mask), 32'(mem[1]));
    check("mode",         32'(mode),          32'(mem[3]));
    check("disc_pol",     32'(disc_polarity), 32'(mem[61]));
    check("vco_ctrl",     32'(vco_control),   32'(mem[62]));
    check("pll_div",      32'(pll_div_ratio), 32'(mem[63]));
    check("slow_mode",    32'(slow_mode),     32'(mem[64]));
    check("trig_delay",   32'(trig_delay),    32'(mem[65]));
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] rd);
    rd = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tick(1'b1, b[7-k]);
      rd[k] = serial_out;
    end
    check_cfg();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0);
  endtask

  function automatic logic [7:0] pick_addr();
    int r;
    r = $urandom_range(0, 9);
    if (r < 3) return 8'($urandom_range(1, 3));
    if (r < 5) return 8'($urandom_range(4, 59));
    if (r < 7) return 8'($urandom_range(60, 66));
    return 8'($urandom_range(0, 255));
  endfunction

  initial begin
    logic [7:0] rd;
    logic [7:0] b;
    int n;

    sel_tab[0]  = '{8'd4,   3'd0, 8'h01};
    sel_tab[1]  = '{8'd10,  3'd6, 8'h01};
    sel_tab[2]  = '{8'd11,  3'd0, 8'h02};
    sel_tab[3]  = '{8'd32,  3'd0, 8'h10};
    sel_tab[4]  = '{8'd45,  3'd6, 8'h20};
    sel_tab[5]  = '{8'd53,  3'd0, 8'h80};
    sel_tab[6]  = '{8'd59,  3'd6, 8'h80};
    sel_tab[7]  = '{8'd3,   3'd7, 8'h00};
    sel_tab[8]  = '{8'd60,  3'd7, 8'h00};
    sel_tab[9]  = '{8'd0,   3'd7, 8'h00};
    sel_tab[10] = '{8'd255, 3'd7, 8'h00};

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    m_addr = 0; m_bits = 0; m_idle = 0; m_pend = -1;
    m_in_data = 1'b0; m_clk_en = 1'b0; m_sh = 8'h00;

    // Reset
    rstn = 1'b0; sclk = 1'b0; serial_in = 1'b0; pll_locked = 8'h01;
    repeat (3) @(posedge iclk);
    #1;
    check("rst_select", 32'(select_reg), 32'h7);
    check("rst_load",   32'(load_cnt_ser), 32'h0);
    check("rst_clk_en", 32'(clk_enable), 32'h0);
    check("rst_so",     32'(serial_out), 32'h0);
    check("rst_pulses", 32'({inst_rst, inst_readout, inst_start}), 32'h0);
    check_cfg();
    @(negedge iclk);
    rstn = 1'b1;

    // tcm / instruction / mode write; inst_rst pulse is checked inside tick
    idle(IDLE);
    send_byte(8'd1, rd);
    send_byte(8'h29, rd);
    send_byte(8'h01, rd);
    send_byte(8'h04, rd);
    check("tcm_const",  32'(trigger_channel_mask), 32'h29);
    check("mode_const", 32'(mode), 32'h04);

    // Counter select sweep, then pll_locked readback at address 60
    idle(IDLE);
    send_byte(8'd4, rd);
    for (int i = 4; i < 60; i++) begin
      check("sweep_sel",  32'(select_reg),   32'((i - 4) % 7));
      check("sweep_load", 32'(load_cnt_ser), 32'(1 << ((i - 4) / 7)));
      send_byte(8'h00, rd);
      check("sweep_cnt_rd", 32'(rd), 32'h0);
    end
    send_byte(8'h00, rd);
    check("pll_locked_rd", 32'(rd), 32'h01);

    // Write 61..65
    idle(IDLE);
    send_byte(8'd61, rd);
    send_byte(8'hA9, rd);
    send_byte(8'h36, rd);
    send_byte(8'h07, rd);
    send_byte(8'h00, rd);
    send_byte(8'h01, rd);
    check("disc_const", 32'(disc_polarity), 32'hA9);
    check("vco_const",  32'(vco_control),   32'h36);
    check("div_const",  32'(pll_div_ratio), 32'h07);
    check("slow_const", 32'(slow_mode),     32'h00);
    check("trig_const", 32'(trig_delay),    32'h01);

    // Readback of old contents while zeros are written
    idle(IDLE);
    send_byte(8'd1, rd);
    send_byte(8'h00, rd); check("rb_tcm",  32'(rd), 32'h29);
    send_byte(8'h00, rd); check("rb_inst", 32'(rd), 32'h01);
    send_byte(8'h00, rd); check("rb_mode", 32'(rd), 32'h04);
    check("tcm_zeroed", 32'(trigger_channel_mask), 32'h00);

    // Table-driven select vectors
    for (int i = 0; i < 11; i++) begin
      idle(IDLE);
      send_byte(sel_tab[i].addr, rd);
      check("tab_sel",  32'(select_reg),   32'(sel_tab[i].sel));
      check("tab_load", 32'(load_cnt_ser), 32'(sel_tab[i].load));
    end

    // Invalid addresses followed by idle reset
    for (int a = 60; a < 256; a++) begin
      send_byte(8'(a), rd);
      check("inv_sel",  32'(select_reg),   32'h7);
      check("inv_load", 32'(load_cnt_ser), 32'h0);
      idle(IDLE);
      check_cfg();
    end

    // Instructions
    send_byte(8'd2, rd);
    send_byte(8'h01, rd);
    tick(1'b0, 1'b0);
    check("rst_pulse",   32'(inst_rst),   32'h1);
    check("rst_clk_off", 32'(clk_enable), 32'h0);
    tick(1'b0, 1'b0);
    check("rst_pulse_end", 32'({inst_rst, inst_readout, inst_start}), 32'h0);
    idle(IDLE);
    send_byte(8'd2, rd);
    send_byte(8'h02, rd);
    tick(1'b0, 1'b0);
    check("readout_pulse", 32'(inst_readout), 32'h1);
    tick(1'b0, 1'b0);
    check("readout_end", 32'(inst_readout), 32'h0);
    idle(IDLE);
    send_byte(8'd2, rd);
    send_byte(8'h03, rd);
    tick(1'b0, 1'b0);
    check("start_pulse", 32'(inst_start), 32'h1);
    check("start_clk",   32'(clk_enable), 32'h1);
    tick(1'b0, 1'b0);
    check("start_end",   32'(inst_start), 32'h0);
    idle(IDLE + 4);
    check("clk_en_sticky", 32'(clk_enable), 32'h1);

    // Partial byte interrupted by idle is discarded
    tick(1'b1, 1'b1); tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    idle(IDLE);
    send_byte(8'd5, rd);
    check("partial_sel",  32'(select_reg),   32'h1);
    check("partial_load", 32'(load_cnt_ser), 32'h01);
    idle(IDLE - 1);
    check("short_idle_phase", 32'(dbg_phase), 32'h1);
    send_byte(8'h00, rd);
    check("short_idle_sel", 32'(select_reg), 32'h2);

    // Randomized streams against the model
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 9) == 0) pll_locked = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        idle(IDLE + $urandom_range(0, 3));
        send_byte(pick_addr(), rd);
      end
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        if (!m_in_data) b = pick_addr();
        else if (m_addr == 2) b = 8'($urandom_range(0, 4));
        else b = 8'($urandom_range(0, 255));
        send_byte(b, rd);
        idle($urandom_range(0, 2));
      end
      if ($urandom_range(0, 15) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 7)); k++) tick(1'b1, 1'($urandom_range(0, 1)));
        idle(IDLE);
        check_cfg();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_ctrl.md
Name: spi_ctrl

Overview:
- Serial configuration/readout slave for the digitizer ASIC.
- A serial byte stream, input MSB-first, first sets an 8-bit register address; each following byte writes the addressed register while its previous contents shift out, then the address auto-increments.
- Drives the configuration outputs, one-cycle instruction pulses, and the counter-readout select lines (load_cnt_ser/select_reg) used by the external counter chain.

Parameters:
- IDLE_RESET_CYCLES, 8, consecutive iclk rising edges with sclk low that trigger the internal protocol reset.

Ports:
- iclk  in  1  system clock; all state changes on its rising edge.
- rstn  in  1  asynchronous active-low reset.
- sclk  in  1  bit-valid qualifier, sampled on iclk rise; 1 = serial_in carries a bit. Must be stable high at the iclk edge.
- serial_in  in  1  serial data, MSB first.
- pll_locked  in  8  status, read-only at address 60.
- load_cnt_ser  out  8  one-hot counter-channel select.
- select_reg  out  3  word select within a channel; 3'b111 = none.
- clk_enable  out  1  sticky run enable.
- inst_rst, inst_readout, inst_start  out  1 each  one-cycle instruction pulses.
- trigger_channel_mask, mode, disc_polarity, vco_control, pll_div_ratio, slow_mode, trig_delay  out  8 each  configuration registers.
- serial_out  out  1  readback data, LSB first.

Behaviour:
- rstn low (async): clears all registers, instruction register, address, bit counter, idle counter, serial_out, pulse outputs and clk_enable to 0. After reset the block is in the ADDRESS phase.
- Bit sampling: on an iclk rise with sclk=1, shift serial_in into an 8-bit shift register and increment bit count 0..7. The idle counter clears on this edge.
- Byte complete: on the 8th bit edge the byte takes effect on that same edge.
  - ADDRESS phase: addr <= byte, move to DATA phase.
  - DATA phase: write byte to regs[addr] if writable, then addr <= addr+1, wrapping 255->0.
- Register map:
  - 1 trigger_channel_mask RW; 2 instruction RW; 3 mode RW.
  - 4..59 counter words: write ignored, serial_out=0, external chain supplies data.
  - 60 pll_locked RO.
  - 61 disc_polarity, 62 vco_control, 63 pll_div_ratio, 64 slow_mode, 65 trig_delay, all RW.
  - 0 and 66..255: writes ignored, read 0.
- Readback: on the bit-k sample edge, k=0..7, serial_out <= regs[addr][k]. The value is taken from pre-write contents, so a read/write byte returns the old value.
- Counter select is combinational from addr.
  - addr 4..59: select_reg=(addr-4)%7 and load_cnt_ser=1<<((addr-4)/7).
  - Any other addr, or ADDRESS phase before the first address byte: select_reg=3'b111, load_cnt_ser=0.
- Instruction execution:
  - A write to addr 2 sets a pending flag.
  - The next iclk rise, regardless of sclk, clears the flag and decodes the instruction:
    - 1: inst_rst=1 and clk_enable<=0.
    - 2: inst_readout=1.
    - 3: inst_start=1 and clk_enable<=1.
    - Other values: no-op.
  - The following rise returns the pulses to 0. clk_enable holds its value.
- Internal reset: IDLE_RESET_CYCLES consecutive iclk rises with sclk=0 return the block to the ADDRESS phase with bit count 0. Registers and clk_enable are retained.
- A partial byte interrupted by idle is discarded.

Decomposition:
- Shared package spi_pkg: address constants (ADDR_TCM=1, ADDR_INST=2, ADDR_MODE=3, ADDR_CNT_FIRST=4, ADDR_CNT_LAST=59, ADDR_PLL_LOCKED=60, ADDR_DISC_POL=61 … ADDR_TRIG_DELAY=65), instruction codes (INST_RST=1, INST_READOUT=2, INST_START=3), and a phase enum {ADDRESS, DATA}.
- One sub-module, spi_shift_in: shift register, bit counter and idle counter. It outputs byte_valid and idle_reset.

Test Plan:
- Write tcm, instruction, mode: address 1, then 0x29, 0x01, 0x04 -> trigger_channel_mask=0x29, instruction=0x01, mode=0x04. inst_rst pulses one cycle after the second byte.
- Counter select sweep: after idle reset, address 4, then 56 zero bytes.
  - Before byte i: select_reg=(i-4)%7 and load_cnt_ser=1<<((i-4)/7).
  - 57th zero byte returns 0x01 when pll_locked=0x01.
- Write 61..65: bytes 0xA9, 0x36, 0x07, 0x00, 0x01 -> the five outputs hold these values.
- Readback: address 1, three zero bytes -> serial_out streams LSB-first 0x29, 0x01, 0x04. The zeros are written afterwards.
- Invalid addresses: for each address 60..255 followed by idle reset -> load_cnt_ser=0, select_reg=3'b111.
- Instructions: address 2, then 0x01 -> next edge inst_rst=1 and clk_enable=0, following edge all pulses 0.
  - 0x02 -> inst_readout pulses.
  - 0x03 -> inst_start pulses and clk_enable=1, which stays 1 after the pulse and across idle reset.
